// File: rtl/clk_div_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clk_div_ctrl                                                     |
// | Brief    : Runtime-programmable glitch-free clock divider with controller.  |
// |            Odd ratios (50% duty) enabled by macro CLK_DIV_CTRL_ODD_EN.      |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module clk_div_ctrl #(
   parameter int CNT_W    = 8,
   parameter int DIV_INIT = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic [CNT_W-1:0] cur_div,
   output logic             busy,
   output logic             tick,
   output logic             clk_out
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_PEND = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_div_init = CNT_W'(DIV_INIT);
   localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [CNT_W-1:0] r_pend_div, w_pend_div_nxt;
   logic [CNT_W-1:0] w_div_nxt;
   logic             r_pend_vld, w_pend_vld_nxt;
   logic             r_active, w_active_nxt;
   logic             r_clk_p, w_clk_p_nxt;
   logic             w_tick_nxt, w_err_nxt;
   logic             w_accept, w_legal, w_wrap;

`ifdef CLK_DIV_CTRL_ODD_EN
   assign w_legal = (cfg_div > c_one);
`else
   assign w_legal = (cfg_div > c_one) && !cfg_div[0];
`endif

   assign cfg_ready = (r_state != S_PEND);
   assign busy      = (r_state == S_PEND);
   assign w_accept  = cfg_valid && cfg_ready;
   assign w_wrap    = (r_cnt == cur_div - c_one);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_div_nxt      = cur_div;
      w_pend_div_nxt = r_pend_div;
      w_pend_vld_nxt = r_pend_vld;
      w_active_nxt   = r_active;
      w_err_nxt      = w_accept && !w_legal;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt    = '0;
            w_active_nxt = 1'b0;
            if (w_accept && w_legal) w_div_nxt = cfg_div;
            if (en) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (w_accept && w_legal) begin
               w_pend_div_nxt = cfg_div;
               w_pend_vld_nxt = 1'b1;
               w_state_nxt    = S_PEND;
            end
            if (!en) w_state_nxt = S_PEND;
         end
         S_PEND: begin
            // Boundary is the last low cycle, so both clock phases are low here
            if (w_wrap) begin
               if (r_pend_vld) begin
                  w_div_nxt      = r_pend_div;
                  w_pend_vld_nxt = 1'b0;
               end
               w_state_nxt = en ? S_RUN : S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (r_state != S_IDLE) begin
         if (!r_active) begin
            w_cnt_nxt    = '0;
            w_active_nxt = 1'b1;
         end else if (w_wrap) begin
            w_cnt_nxt    = '0;
            w_active_nxt = (w_state_nxt != S_IDLE);
         end else begin
            w_cnt_nxt = r_cnt + c_one;
         end
      end

      w_clk_p_nxt = w_active_nxt && (w_cnt_nxt < (w_div_nxt >> 1));
      w_tick_nxt  = w_active_nxt && (w_cnt_nxt == '0);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt      <= '0;
         cur_div    <= c_div_init;
         r_pend_div <= '0;
         r_pend_vld <= 1'b0;
         r_active   <= 1'b0;
         r_clk_p    <= 1'b0;
         tick       <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         cur_div    <= w_div_nxt;
         r_pend_div <= w_pend_div_nxt;
         r_pend_vld <= w_pend_vld_nxt;
         r_active   <= w_active_nxt;
         r_clk_p    <= w_clk_p_nxt;
         tick       <= w_tick_nxt;
         cfg_err    <= w_err_nxt;
      end
   end

`ifdef CLK_DIV_CTRL_ODD_EN
   logic r_clk_n;

   // Half-cycle extension only for odd ratios; even ratios stay exact
   always_ff @(negedge clk or negedge rstn) begin
      if (!rstn) r_clk_n <= 1'b0;
      else       r_clk_n <= r_clk_p & cur_div[0];
   end

   assign clk_out = r_clk_p | r_clk_n;
`else
   assign clk_out = r_clk_p;
`endif

endmodule
`default_nettype wire

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Runtime-programmable clock divider with a controller that sequences ratio changes and start/stop. Changes apply only at period boundaries, so `clk_out` never glitches or produces a runt pulse. The block sits between the register/config interface and clock consumers that need a software-selectable divided clock. It replaces fixed-ratio dividers wherever the ratio must change in the field.

## Interface
- `CNT_W`, 8: width of the ratio and the period counter.
- `DIV_INIT`, 5: ratio loaded at reset. Must be legal (2..2^CNT_W-1; even only if odd support is compiled out).
- `clk`  in  1  source clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `en`  in  1  run request. Level-sensitive.
- `cfg_valid`  in  1  new ratio offered.
- `cfg_div`  in  CNT_W  requested ratio N.
- `cfg_ready`  out  1  ratio can be accepted this cycle.
- `cfg_err`  out  1  one-cycle pulse when an accepted ratio is illegal.
- `cur_div`  out  CNT_W  ratio currently in effect.
- `busy`  out  1  ratio change or stop is pending.
- `tick`  out  1  one-cycle pulse on the posedge that starts each output period.
- `clk_out`  out  1  divided clock.

## Operation
- FSM states:
  - IDLE: stopped, `clk_out` low.
  - RUN: dividing.
  - PEND: change and/or stop queued, waiting for the period boundary.
- Period counter `cnt` runs 0..N-1 and wraps to 0. High length is H = floor(N/2).
- `clk_p` (posedge register) is high exactly while `cnt` is in 0..H-1.
- Odd N: `clk_n` is `clk_p` re-registered on negedge, and `clk_out = clk_p | clk_n`. This gives H+0.5 cycles high per N, i.e. 50% duty.
- Even N: `clk_out = clk_p`.
- Handshake: a transfer occurs when `cfg_valid && cfg_ready`. `cfg_ready` = 1 in IDLE and RUN, 0 in PEND.
- Illegal ratios:
  - Legality check runs at acceptance. Illegal values are N=0, N=1, and odd N when odd support is compiled out.
  - An illegal value pulses `cfg_err` for the next cycle and leaves `cur_div` and the state unchanged.
- Legal ratio accepted in IDLE: `cur_div` updates on the next posedge; no output effect.
- Legal ratio accepted in RUN: stored as pending, state goes to PEND, `busy` = 1.
- IDLE→RUN when `en` = 1. RUN→PEND when `en` = 0 (stop queued).
- PEND is left at the posedge where `cnt` = N_old-1, the last low cycle, when `clk_p` and `clk_n` are both low:
  - A pending ratio loads into `cur_div` and `cnt` restarts at 0.
  - If a stop is queued or `en` = 0, the state goes to IDLE; otherwise it returns to RUN.
- `en` reasserted while PEND with a stop queued cancels the stop. A queued ratio change stays pending.
- A stop and a ratio change queued together both apply at the same boundary.
- `tick` pulses whenever `cnt` becomes 0 in RUN, including the first period after IDLE and the first period at a new ratio.

## Timing
- Reset values: state IDLE, `cnt` = 0, `clk_out` = 0, `cfg_ready` = 1, `cfg_err` = 0, `busy` = 0, `tick` = 0, `cur_div` = `DIV_INIT`.
- Reset is asynchronous mid-operation: `clk_out` goes low immediately and any pending change is discarded.
- Start latency: `en` sampled high at posedge k → `tick` = 1 and `clk_out` = 1 after posedge k+1.
- Stop latency: `en` sampled low in RUN → `clk_out` completes the current period, then stays low. The last low phase is never truncated.
- Change latency: a ratio accepted at posedge k takes effect at the first boundary after k. Worst case is N_old cycles.
- `cfg_err` asserts on the posedge after the acceptance edge and lasts exactly 1 cycle.
- Every `clk_out` high pulse is H or H+0.5 cycles of the ratio in effect when the pulse started. No pulse is shorter than 1 source cycle.

## Configuration
- `CLK_DIV_CTRL_ODD_EN` defined:
  - Odd ratios ≥3 are legal.
  - The negedge `clk_n` register exists and is ORed into `clk_out`, giving 50% duty for odd N.
- Not defined:
  - No negedge logic; `clk_out = clk_p`.
  - Odd ratios are illegal and produce `cfg_err`.
  - `DIV_INIT` must be even.

## Test plan
- Reset then `en` = 1 with `DIV_INIT` = 5 and odd support on → `clk_out` high 2.5 cycles, low 2.5 cycles, `tick` every 5 cycles, `cur_div` = 5.
- While RUN at N=4, accept `cfg_div` = 6 mid-period → `busy` = 1 and `cfg_ready` = 0 until the `cnt` = 3 boundary. The next period is 3 high / 3 low, `cur_div` = 6, with no short pulse.
- Offer `cfg_div` = 1, then 0, then (with odd support off) 7 → each produces a 1-cycle `cfg_err`; `cur_div` and `clk_out` are undisturbed.
- Deassert `en` 1 cycle into the high phase at N=8 → the high phase lasts the full 4 cycles and the low phase 4, then IDLE with `clk_out` = 0.
- Queue ratio 3 and drop `en` in the same period at N=4 → at the boundary, IDLE with `cur_div` = 3. Re-enable → periods of 3.
- Pulse `rstn` low during the `clk_out` high phase with a change pending → `clk_out` drops immediately. After release: `cur_div` = `DIV_INIT`, state IDLE, `busy` = 0.
